tri_64x72_wr_arb: RTL and testbench

Write arbiter and sequencer in front of the 64-entry x 72-bit 1r1w register-file array. Two write requesters share the array's single write port through a round-robin enqueue arbiter and a shared in-order write FIFO. The FIFO drains one entry per cycle into the array. A read port sits alongside and returns data with the array's one-cycle read latency. When compiled in, reads are forwarded from pending FIFO entries so that they always return the newest accepted value.

---
 rtl/tri_64x72_wr_arb.sv | 111 +++++++++++
 tb/tb_tri_64x72_wr_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tri_64x72_wr_arb.sv
// tri_64x72_wr_arb: round-robin write arbiter and in-order write FIFO ahead of a 64x72 1r1w array; define TRI_WR_ARB_BYPASS_EN to forward reads from pending writes
module tri_64x72_wr_arb #(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 72
) (
  input  logic                     clk,
  input  logic                     sreset,
  input  logic                     req0_val,
  input  logic                     req1_val,
  output logic                     req0_rdy,
  output logic                     req1_rdy,
  input  logic [0:ADDR_WIDTH-1]    req0_adr,
  input  logic [0:ADDR_WIDTH-1]    req1_adr,
  input  logic [0:DATA_WIDTH-1]    req0_dat,
  input  logic [0:DATA_WIDTH-1]    req1_dat,
  input  logic                     wr_hold,
  input  logic                     rd_val,
  input  logic [0:ADDR_WIDTH-1]    rd_adr,
  output logic                     rd_rdy,
  output logic                     rd_dat_val,
  output logic [0:DATA_WIDTH-1]    rd_dat,
  output logic                     ary_wr_act,
  output logic [0:ADDR_WIDTH-1]    ary_wr_adr,
  output logic [0:DATA_WIDTH-1]    ary_di,
  output logic                     ary_rd0_act,
  output logic [0:ADDR_WIDTH-1]    ary_rd0_adr,
  input  logic [0:DATA_WIDTH-1]    ary_do0,
  output logic [0:$clog2(DEPTH)]   fifo_cnt,
  output logic                     fifo_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_WIDTH-1:0] adr_q [DEPTH];
  logic [DATA_WIDTH-1:0] dat_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] cnt_q;
  logic last_gnt, rst_q, dv_q, act, full, g0, g1, enq, hit;
`ifdef TRI_WR_ARB_BYPASS_EN
  logic hit_q;
  logic [DATA_WIDTH-1:0] byp, byp_q;
`endif
  assign act = ~sreset & ~rst_q;
  assign full = cnt_q == CW'(DEPTH);
  assign g0 = req0_val & (~req1_val | last_gnt);
  assign g1 = req1_val & (~req0_val | ~last_gnt);
  assign req0_rdy = act & ~full & g0;
  assign req1_rdy = act & ~full & g1;
  assign enq = req0_rdy | req1_rdy;
  assign fifo_cnt = act ? cnt_q : '0;
  assign fifo_empty = ~act | (cnt_q == '0);
  assign ary_wr_act = act & (cnt_q != '0) & ~wr_hold;
  assign ary_wr_adr = act ? adr_q[head_q] : '0;
  assign ary_di = act ? dat_q[head_q] : '0;
  assign ary_rd0_act = rd_val & rd_rdy;
  assign ary_rd0_adr = act ? rd_adr : '0;
  assign rd_dat_val = act & dv_q;
`ifdef TRI_WR_ARB_BYPASS_EN
  assign rd_rdy = act;
  assign rd_dat = act ? (hit_q ? byp_q : ary_do0) : '0;
`else
  assign rd_rdy = act & ~hit;
  assign rd_dat = act ? ary_do0 : '0;
`endif
  // scan pending entries oldest to newest so the newest match wins
  always_comb begin
    hit = 1'b0;
`ifdef TRI_WR_ARB_BYPASS_EN
    byp = '0;
`endif
    for (int i = 0; i < DEPTH; i++)
      if (CW'(i) < cnt_q && adr_q[head_q + PW'(i)] == rd_adr) begin
        hit = 1'b1;
`ifdef TRI_WR_ARB_BYPASS_EN
        byp = dat_q[head_q + PW'(i)];
`endif
      end
  end
  // fifo pointers, occupancy, grant history and read-valid pipeline
  always_ff @(posedge clk)
    if (sreset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      last_gnt <= 1'b1;
      rst_q <= 1'b1;
      dv_q <= 1'b0;
    end else begin
      rst_q <= 1'b0;
      head_q <= head_q + PW'(ary_wr_act);
      tail_q <= tail_q + PW'(enq);
      cnt_q <= cnt_q + CW'(enq) - CW'(ary_wr_act);
      if (enq) last_gnt <= req1_rdy;
      dv_q <= ary_rd0_act;
    end
  // fifo entry storage written at the tail by the granted requester
  always_ff @(posedge clk)
    if (enq) begin
      adr_q[tail_q] <= req0_rdy ? req0_adr : req1_adr;
      dat_q[tail_q] <= req0_rdy ? req0_dat : req1_dat;
    end
`ifdef TRI_WR_ARB_BYPASS_EN
  // capture forwarded data alongside the array read
  always_ff @(posedge clk)
    if (sreset) hit_q <= 1'b0;
    else begin
      hit_q <= ary_rd0_act & hit;
      byp_q <= byp;
    end
`endif
endmodule

// File: tb/tb_tri_64x72_wr_arb.sv
// tb_tri_64x72_wr_arb: scoreboard bench for tri_64x72_wr_arb with a behavioural 64x72 array model
module tb_tri_64x72_wr_arb;
  logic clk = 1'b0;
  logic sreset, req0_val, req1_val, req0_rdy, req1_rdy, wr_hold, rd_val, rd_rdy, rd_dat_val;
  logic ary_wr_act, ary_rd0_act, fifo_empty;
  logic [5:0] req0_adr, req1_adr, rd_adr, ary_wr_adr, ary_rd0_adr;
  logic [71:0] req0_dat, req1_dat, rd_dat, ary_di, ary_do0;
  logic [2:0] fifo_cnt;
  logic [71:0] mem [64];
  logic [5:0] wqa [$];
  logic [71:0] wqd [$];
  logic [71:0] rq [$];
  int checks = 0, errors = 0;
  localparam logic [71:0] A = 72'hA0_0000_0000_0000_0000;
  localparam logic [71:0] B = 72'hB0_0000_0000_0000_0000;
  localparam logic [71:0] C = 72'hC0_0000_0000_0000_0000;

  tri_64x72_wr_arb dut (
    .clk(clk), .sreset(sreset),
    .req0_val(req0_val), .req1_val(req1_val), .req0_rdy(req0_rdy), .req1_rdy(req1_rdy),
    .req0_adr(req0_adr), .req1_adr(req1_adr), .req0_dat(req0_dat), .req1_dat(req1_dat),
    .wr_hold(wr_hold), .rd_val(rd_val), .rd_adr(rd_adr), .rd_rdy(rd_rdy),
    .rd_dat_val(rd_dat_val), .rd_dat(rd_dat),
    .ary_wr_act(ary_wr_act), .ary_wr_adr(ary_wr_adr), .ary_di(ary_di),
    .ary_rd0_act(ary_rd0_act), .ary_rd0_adr(ary_rd0_adr), .ary_do0(ary_do0),
    .fifo_cnt(fifo_cnt), .fifo_empty(fifo_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] stale(int i);
    return 72'hEE_0000_0000_0000_0000 | 72'(i);
  endfunction

  always @(posedge clk) begin
    if (ary_rd0_act) ary_do0 <= mem[ary_rd0_adr];
    if (ary_wr_act) mem[ary_wr_adr] <= ary_di;
  end

  task automatic chk(string nm, logic [71:0] got, logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [5:0] a, logic [71:0] d);
    wqa.push_back(a);
    wqd.push_back(d);
  endtask

  always @(negedge clk) begin
    if (ary_wr_act) begin
      if (wqa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected got adr %h exp no write", ary_wr_adr);
      end else begin
        chk("wr_adr", 72'(ary_wr_adr), 72'(wqa.pop_front()));
        chk("wr_dat", ary_di, wqd.pop_front());
      end
    end
    if (rd_dat_val) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected got %h exp no read data", rd_dat);
      end else chk("rd_dat", rd_dat, rq.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = stale(i);
    {sreset, req0_val, req1_val, wr_hold, rd_val} = 5'b10000;
    req0_adr = '0; req1_adr = '0; rd_adr = '0; req0_dat = '0; req1_dat = '0;
    cyc(2);
    req0_val = 1; rd_val = 1; #1;
    chk("rst_empty", fifo_empty, 1);
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_req0_rdy", req0_rdy, 0);
    chk("rst_rd_rdy", rd_rdy, 0);
    chk("rst_rd_dat_val", rd_dat_val, 0);
    sreset = 0; #1;
    chk("post_rst_req0_rdy", req0_rdy, 0);
    chk("post_rst_rd_rdy", rd_rdy, 0);
    req0_val = 0; rd_val = 0;
    cyc; #1;
    chk("idle_rd_rdy", rd_rdy, 1);
    req0_adr = 6'h01; req1_adr = 6'h02;
    req0_val = 1; req1_val = 1;
    for (int k = 0; k < 4; k++) begin
      req0_dat = A + 72'(k); req1_dat = B + 72'(k); #1;
      chk("cont_req0_rdy", req0_rdy, k % 2 == 0);
      chk("cont_req1_rdy", req1_rdy, k % 2 == 1);
      if (k % 2 == 0) wr(6'h01, A + 72'(k));
      else wr(6'h02, B + 72'(k));
      cyc;
    end
    req0_val = 0; req1_val = 0;
    cyc;
    chk("cont_empty", fifo_empty, 1);
    wr_hold = 1; req0_val = 1;
    for (int k = 0; k < 5; k++) begin
      req0_adr = 6'(6'h30 + k); req0_dat = C + 72'(k); #1;
      chk("full_req0_rdy", req0_rdy, k < 4);
      if (k < 4) begin
        wr(6'(6'h30 + k), C + 72'(k));
        cyc;
      end
    end
    chk("full_cnt", fifo_cnt, 4);
    wr_hold = 0; #1;
    chk("full_rdy_on_deq", req0_rdy, 0);
    chk("full_wr_act", ary_wr_act, 1);
    cyc;
    chk("full_rdy_after", req0_rdy, 1);
    wr(6'h34, C + 72'(4));
    cyc;
    req0_val = 0;
    cyc(3);
    chk("full_drained", fifo_empty, 1);
`ifdef TRI_WR_ARB_BYPASS_EN
    wr_hold = 1; req0_val = 1; req0_adr = 6'h10; req0_dat = {18{4'hA}};
    wr(6'h10, {18{4'hA}});
    cyc;
    req0_dat = {18{4'h5}};
    wr(6'h10, {18{4'h5}});
    cyc;
    req0_val = 0; rd_val = 1; rd_adr = 6'h10; #1;
    chk("byp_rd_rdy", rd_rdy, 1);
    rq.push_back({18{4'h5}});
    cyc;
    rd_adr = 6'h11;
    rq.push_back(stale(17));
    cyc;
    rd_val = 0; wr_hold = 0;
    cyc(2);
    chk("byp_drained", fifo_empty, 1);
    wr_hold = 1; req0_val = 1; req0_adr = 6'h07; req0_dat = {9{8'hC7}};
    wr(6'h07, {9{8'hC7}});
    cyc;
    req0_val = 0; wr_hold = 0; rd_val = 1; rd_adr = 6'h07; #1;
    chk("coll_wr_act", ary_wr_act, 1);
    chk("coll_rd_rdy", rd_rdy, 1);
    rq.push_back({9{8'hC7}});
    cyc;
    rd_val = 0;
    cyc;
`else
    wr_hold = 1; req0_val = 1; req0_adr = 6'h20; req0_dat = {9{8'h5A}};
    wr(6'h20, {9{8'h5A}});
    cyc;
    req0_val = 0; rd_val = 1; rd_adr = 6'h21; #1;
    chk("stall_other_rdy", rd_rdy, 1);
    rq.push_back(stale(33));
    cyc;
    rd_adr = 6'h20; #1;
    chk("stall_rdy0", rd_rdy, 0);
    cyc;
    chk("stall_rdy1", rd_rdy, 0);
    wr_hold = 0; #1;
    chk("stall_rdy_head", rd_rdy, 0);
    chk("stall_wr_act", ary_wr_act, 1);
    cyc;
    chk("stall_rdy_drained", rd_rdy, 1);
    rq.push_back({9{8'h5A}});
    cyc;
    rd_val = 0;
    cyc;
`endif
    wr_hold = 1; req0_val = 1;
    for (int k = 0; k < 3; k++) begin
      req0_adr = 6'(6'h3A + k); req0_dat = 72'(k);
      cyc;
    end
    req0_val = 0; rd_val = 1; rd_adr = 6'h05; #1;
    chk("mid_cnt", fifo_cnt, 3);
    chk("mid_rd_rdy", rd_rdy, 1);
    cyc;
    rd_val = 0; wr_hold = 0; sreset = 1; #1;
    chk("mid_rst_dv", rd_dat_val, 0);
    chk("mid_rst_wr_act", ary_wr_act, 0);
    chk("mid_rst_empty", fifo_empty, 1);
    cyc;
    chk("mid_rst_cnt", fifo_cnt, 0);
    chk("mid_rst_dv2", rd_dat_val, 0);
    sreset = 0;
    cyc;
    chk("mid_post_empty", fifo_empty, 1);
    req0_val = 1; req1_val = 1; req0_adr = 6'h01; req1_adr = 6'h02;
    req0_dat = A + 72'h55; req1_dat = B + 72'h55; #1;
    chk("mid_cont_req0_rdy", req0_rdy, 1);
    chk("mid_cont_req1_rdy", req1_rdy, 0);
    wr(6'h01, A + 72'h55);
    cyc;
    chk("mid_cont2_req1_rdy", req1_rdy, 1);
    wr(6'h02, B + 72'h55);
    cyc;
    req0_val = 0; req1_val = 0;
    cyc(3);
    chk("end_empty", fifo_empty, 1);
    chk("wq_drained", wqa.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
